// File: rtl/msfsm_io_event_adapter.sv
// Event adapter around the XOR-gate MSFSM cluster: level inputs become held
// plus/minus events, and the FSMs' output pulses are folded back into a level.
module msfsm_io_event_adapter #(
  parameter int              N_IN     = 2,
  parameter logic [N_IN-1:0] IN_INIT  = {N_IN{1'b0}},
  parameter logic            OUT_INIT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] in_level,
  input  logic [N_IN-1:0] in_ready,
  output logic [N_IN-1:0] ev_plus,
  output logic [N_IN-1:0] ev_minus,
  input  logic            out_plus,
  input  logic            out_minus,
  output logic            out_level,
  output logic            out_change,
  output logic            busy,
  output logic [N_IN-1:0] err_glitch,
  output logic            err_out
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_ARMED  = 1'b1
  } ch_state_e;

  ch_state_e       state_q [N_IN];
  ch_state_e       state_d [N_IN];
  logic [N_IN-1:0] trk_q, trk_d;
  logic [N_IN-1:0] pol_q, pol_d;
  logic [N_IN-1:0] ready_q;
  logic [N_IN-1:0] ev_plus_q, ev_plus_d;
  logic [N_IN-1:0] ev_minus_q, ev_minus_d;
  logic [N_IN-1:0] err_glitch_q, err_glitch_d;
  logic            busy_q, busy_d;
  logic            out_level_q, out_level_d;
  logic            out_change_q, out_change_d;
  logic            err_out_q, err_out_d;

  // Per-channel next state; events are decoded from the next state so the
  // outputs come straight from flops.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      state_d[i]      = state_q[i];
      trk_d[i]        = trk_q[i];
      pol_d[i]        = pol_q[i];
      err_glitch_d[i] = err_glitch_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (in_level[i] != trk_q[i]) begin
            state_d[i] = ST_ARMED;
            pol_d[i]   = in_level[i];
          end else begin
            state_d[i] = ST_STABLE;
          end
        end
        ST_ARMED: begin
          // Consumption beats a simultaneous revert; the revert re-arms next edge.
          if (ready_q[i] && !in_ready[i]) begin
            trk_d[i]   = pol_q[i];
            state_d[i] = ST_STABLE;
          end else if (in_level[i] == trk_q[i]) begin
            state_d[i]      = ST_STABLE;
            err_glitch_d[i] = 1'b1;
          end else begin
            state_d[i] = ST_ARMED;
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
        end
      endcase
      ev_plus_d[i]  = (state_d[i] == ST_ARMED) &&  pol_d[i];
      ev_minus_d[i] = (state_d[i] == ST_ARMED) && !pol_d[i];
    end
    busy_d = |(ev_plus_d | ev_minus_d);
  end

  // Output-side pulse folding and protocol check.
  always_comb begin
    out_level_d  = out_level_q;
    out_change_d = 1'b0;
    err_out_d    = err_out_q;
    case ({out_plus, out_minus})
      2'b10: begin
        if (!out_level_q) begin
          out_level_d  = 1'b1;
          out_change_d = 1'b1;
        end else begin
          err_out_d = 1'b1;
        end
      end
      2'b01: begin
        if (out_level_q) begin
          out_level_d  = 1'b0;
          out_change_d = 1'b1;
        end else begin
          err_out_d = 1'b1;
        end
      end
      2'b11: begin
        err_out_d = 1'b1;
      end
      default: begin
        out_change_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) begin
        state_q[i] <= ST_STABLE;
      end
      trk_q        <= IN_INIT;
      pol_q        <= {N_IN{1'b0}};
      ready_q      <= {N_IN{1'b0}};
      ev_plus_q    <= {N_IN{1'b0}};
      ev_minus_q   <= {N_IN{1'b0}};
      err_glitch_q <= {N_IN{1'b0}};
      busy_q       <= 1'b0;
      out_level_q  <= OUT_INIT;
      out_change_q <= 1'b0;
      err_out_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        state_q[i] <= state_d[i];
      end
      trk_q        <= trk_d;
      pol_q        <= pol_d;
      ready_q      <= in_ready;
      ev_plus_q    <= ev_plus_d;
      ev_minus_q   <= ev_minus_d;
      err_glitch_q <= err_glitch_d;
      busy_q       <= busy_d;
      out_level_q  <= out_level_d;
      out_change_q <= out_change_d;
      err_out_q    <= err_out_d;
    end
  end

  assign ev_plus    = ev_plus_q;
  assign ev_minus   = ev_minus_q;
  assign err_glitch = err_glitch_q;
  assign busy       = busy_q;
  assign out_level  = out_level_q;
  assign out_change = out_change_q;
  assign err_out    = err_out_q;

endmodule

// File: tb/tb_msfsm_io_event_adapter.sv
// Scoreboard bench: the driver pushes the reference model's expected outputs,
// the monitor pops and compares one entry per clock.
module tb_msfsm_io_event_adapter;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] in_level = '0;
  logic [N-1:0] in_ready = '0;
  logic [N-1:0] ev_plus, ev_minus, err_glitch;
  logic         out_plus = 1'b0;
  logic         out_minus = 1'b0;
  logic         out_level, out_change, busy, err_out;

  always #5 clk = ~clk;

  msfsm_io_event_adapter #(.N_IN(N), .IN_INIT(2'b00), .OUT_INIT(1'b0)) dut (
    .clk(clk), .reset(reset), .in_level(in_level), .in_ready(in_ready),
    .ev_plus(ev_plus), .ev_minus(ev_minus), .out_plus(out_plus),
    .out_minus(out_minus), .out_level(out_level), .out_change(out_change),
    .busy(busy), .err_glitch(err_glitch), .err_out(err_out)
  );

  typedef struct packed {
    logic [N-1:0] evp;
    logic [N-1:0] evm;
    logic         lvl;
    logic         chg;
    logic         bsy;
    logic [N-1:0] eg;
    logic         eo;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: last acknowledged value, pending event, and sticky flags.
  bit m_ack  [N];
  bit m_pend [N];
  bit m_dir  [N];
  bit m_rdy  [N];
  bit m_eg   [N];
  bit m_lvl;
  bit m_eo;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] lv, input logic [N-1:0] rd,
                      input logic p, input logic m);
    exp_t e;
    @(negedge clk);
    reset = r; in_level = lv; in_ready = rd; out_plus = p; out_minus = m;
    e = '0;
    if (r) begin
      for (int c = 0; c < N; c++) begin
        m_ack[c] = 1'b0; m_pend[c] = 1'b0; m_dir[c] = 1'b0; m_rdy[c] = 1'b0; m_eg[c] = 1'b0;
      end
      m_lvl = 1'b0;
      m_eo  = 1'b0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (m_pend[c]) begin
          if (m_rdy[c] && !rd[c]) begin
            m_ack[c]  = m_dir[c];
            m_pend[c] = 1'b0;
          end else if (lv[c] == m_ack[c]) begin
            m_pend[c] = 1'b0;
            m_eg[c]   = 1'b1;
          end
        end else if (lv[c] != m_ack[c]) begin
          m_pend[c] = 1'b1;
          m_dir[c]  = lv[c];
        end
        m_rdy[c] = rd[c];
      end
      if (p && m)                 m_eo = 1'b1;
      else if (p && m_lvl)        m_eo = 1'b1;
      else if (m && !m_lvl)       m_eo = 1'b1;
      else if (p || m) begin
        m_lvl = p;
        e.chg = 1'b1;
      end
    end
    for (int c = 0; c < N; c++) begin
      e.evp[c] = m_pend[c] && m_dir[c];
      e.evm[c] = m_pend[c] && !m_dir[c];
      e.eg[c]  = m_eg[c];
      if (m_pend[c]) e.bsy = 1'b1;
    end
    e.lvl = m_lvl;
    e.eo  = m_eo;
    sb.push_back(e);
  endtask

  // Monitor: one expectation is consumed per active edge.
  always begin : mon
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ev_plus",    ev_plus,    e.evp);
      chk("ev_minus",   ev_minus,   e.evm);
      chk("out_level",  out_level,  e.lvl);
      chk("out_change", out_change, e.chg);
      chk("busy",       busy,       e.bsy);
      chk("err_glitch", err_glitch, e.eg);
      chk("err_out",    err_out,    e.eo);
      chk("ev_exclusive", ev_plus & ev_minus, 0);
    end
  end

  initial begin
    logic [N-1:0] lv, rd;
    logic p, m, r;
    // Reset state
    step(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // Channel 0 rise with ready held, consume, then fall
    step(1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // Channel 1 glitch: armed two cycles then reverted
    step(1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // Channel 0 consumption coinciding with revert, then re-arm minus
    step(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // Output pulses: legal rise, illegal repeat, both together, legal fall
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // Reset while channel 0 is armed and err_out is set
    step(1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    step(1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // Randomised traffic with occasional resets
    lv = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 3) == 0) lv[c] = ~lv[c];
        rd[c] = ($urandom_range(0, 2) != 0);
      end
      p = ($urandom_range(0, 4) == 0);
      m = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 299) == 0);
      step(r, lv, rd, p, m);
    end
    step(1'b0, lv, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
